// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Grants one access per cycle and returns a registered, backpressured response per port.
module dmem_arbiter #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [31:0]       p0_rdata_o,
    output logic              p0_err_o,
    input  logic              p0_rready_i,

    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [31:0]       p1_rdata_o,
    output logic              p1_err_o,
    input  logic              p1_rready_i,

    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NPORT  = 2;

    // last_q = index of the most recently granted port
    logic                          last_q,   last_d;
    logic [NPORT-1:0]              rvalid_q, rvalid_d;
    logic [NPORT-1:0]              err_q,    err_d;
    logic [NPORT-1:0][DATA_W-1:0]  rdata_q,  rdata_d;

    logic [NPORT-1:0]              req;
    logic [NPORT-1:0]              we;
    logic [NPORT-1:0]              rready;
    logic [NPORT-1:0][ADDR_W-1:0]  addr;
    logic [NPORT-1:0][DATA_W-1:0]  wdata;
    logic [NPORT-1:0]              elig;
    logic [NPORT-1:0]              gnt;

    logic                          any_gnt;
    logic                          sel;
    logic                          sel_we;
    logic [ADDR_W-1:0]             sel_addr;
    logic [DATA_W-1:0]             sel_wdata;
    logic                          sel_oor;

    always_comb begin
        req    = {p1_req_i,    p0_req_i};
        we     = {p1_we_i,     p0_we_i};
        rready = {p1_rready_i, p0_rready_i};
        addr   = {p1_addr_i,   p0_addr_i};
        wdata  = {p1_wdata_i,  p0_wdata_i};
    end

    // Eligibility and round-robin selection; grants are masked while in reset.
    always_comb begin
        gnt = '0;
        for (int n = 0; n < NPORT; n++) begin
            elig[n] = req[n] & (~rvalid_q[n] | rready[n]);
        end
        if (rst_n_i) begin
            if (elig[0] && elig[1]) begin
                if (last_q) gnt[0] = 1'b1;
                else        gnt[1] = 1'b1;
            end else if (elig[0]) begin
                gnt[0] = 1'b1;
            end else if (elig[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // Memory drive from the granted port; zeros when idle.
    always_comb begin
        any_gnt   = |gnt;
        sel       = gnt[1];
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (any_gnt) begin
            sel_we    = we[sel];
            sel_addr  = addr[sel];
            sel_wdata = wdata[sel];
        end
        sel_oor     = (sel_addr >= ADDR_W'(DEPTH));
        mem_we_o    = any_gnt & sel_we & ~sel_oor;
        mem_addr_o  = sel_addr;
        mem_wdata_o = sel_wdata;
    end

    // Next-state for the pointer and per-port response slots.
    always_comb begin
        last_d   = last_q;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (gnt[0])      last_d = 1'b0;
        else if (gnt[1]) last_d = 1'b1;
        for (int n = 0; n < NPORT; n++) begin
            if (rvalid_q[n] && rready[n]) begin
                rvalid_d[n] = 1'b0;
            end
            // A grant coinciding with the handshake overwrites the old response.
            if (gnt[n]) begin
                rvalid_d[n] = 1'b1;
                err_d[n]    = sel_oor;
                rdata_d[n]  = (!sel_we && !sel_oor) ? mem_rdata_i : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q   <= 1'b1;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        p0_gnt_o    = gnt[0];
        p1_gnt_o    = gnt[1];
        p0_rvalid_o = rvalid_q[0];
        p1_rvalid_o = rvalid_q[1];
        p0_err_o    = err_q[0];
        p1_err_o    = err_q[1];
        p0_rdata_o  = rdata_q[0];
        p1_rdata_o  = rdata_q[1];
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory: 32 words, word-indexed address, synchronous write, combinational read.
- Port 0 is the core load/store unit. Port 1 is the debug/program-loader port.
- Grants one access per cycle with round-robin fairness.
- Drives the memory's write-enable, address and write-data inputs.
- Returns a registered read response with valid/ready backpressure per port.
- Flags out-of-range addresses as errors and suppresses the write.

Parameters:
- DEPTH, 32: number of 32-bit words in the attached memory; legal address range is 0..DEPTH-1.
- ADDR_W, 32: requester and memory address width (word index).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- p0_req_i  in  1  port 0 access request.
- p0_we_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  ADDR_W  port 0 word address.
- p0_wdata_i  in  32  port 0 write data.
- p0_gnt_o  out  1  port 0 request accepted this cycle (combinational).
- p0_rvalid_o  out  1  port 0 response valid.
- p0_rdata_o  out  32  port 0 read data (0 for writes and errors).
- p0_err_o  out  1  port 0 response is an address error; valid with p0_rvalid_o.
- p0_rready_i  in  1  port 0 accepts response.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o, p1_rready_i: same as port 0, for port 1.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory combinational read data.

Behaviour:
- Reset (rst_n_i=0 at a rising edge):
  - all rvalid, rdata and err registers cleared to 0;
  - round-robin pointer last_o set to 1, so port 0 wins the first contention;
  - while rst_n_i=0, gnt_o and mem_we_o are forced to 0.
- Eligibility: port n is eligible when pn_req_i=1 and its response slot is free (pn_rvalid_o=0, or pn_rvalid_o=1 and pn_rready_i=1 in the same cycle). At most one outstanding response per port.
- Arbitration is combinational, in the same cycle as the request:
  - only one port eligible: that port is granted;
  - both eligible: the port not granted last is granted (port 0 if last_o=1, port 1 if last_o=0);
  - last_o updates on every grant.
- Memory drive:
  - granted port's addr and wdata pass to mem_addr_o and mem_wdata_o;
  - mem_we_o = granted pn_we_i AND address in range;
  - with no grant: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Response: registered, one cycle after grant. At the edge ending the grant cycle:
  - pn_rvalid_o<=1;
  - pn_err_o<=(addr>=DEPTH);
  - pn_rdata_o<=mem_rdata_i for an in-range read, else 0.
  - Writes also produce a response (rdata=0), so requesters get completion ordering.
- Response hold: rvalid, rdata and err stay stable until rvalid&rready. If a new grant coincides with the handshake, the new response replaces the old one at that edge. Otherwise rvalid clears on the handshake edge.
- Requester rule: req, we, addr and wdata must stay stable until gnt. A req dropped before gnt is simply not serviced; no error.
- Back-to-back: a single port with rready held at 1 can be granted every cycle, giving throughput of 1 access/cycle total.
- Read-after-write to the same address on consecutive grants returns the new data, because the write commits at the edge before the read's combinational lookup.
- Reset mid-operation discards pending responses. An access granted in the cycle reset is sampled is not performed, since mem_we_o is forced to 0.

Test Plan:
- Reset, then p0 writes 0xDEADBEEF to addr 5 -> p0_gnt_o=1 the same cycle, mem_we_o=1, mem_addr_o=5; next cycle p0_rvalid_o=1, p0_err_o=0, p0_rdata_o=0.
- p1 reads addr 5 after the previous test -> p1_rdata_o=0xDEADBEEF one cycle after grant.
- Both ports request continuously with rready=1 -> grants alternate p0,p1,p0,p1 starting with p0 after reset; no cycle grants both.
- p0 reads with p0_rready_i=0 for 3 cycles while p0_req_i stays high -> p0_gnt_o stays 0 until the handshake; p0_rdata_o stays stable; p1 is still granted meanwhile.
- p1 writes 0x12345678 to addr 40 (DEPTH=32) -> mem_we_o=0; p1_err_o=1, p1_rdata_o=0; memory contents unchanged (verified by reading all words).
- Assert rst_n_i=0 while p0_rvalid_o=1 and p1 is being granted -> next cycle all rvalid=0; the p1 write did not occur; the first grant after reset goes to p0 under contention.
